// File: rtl/data_ram_lsu.sv
`default_nettype none
// data_ram_lsu: pipelined byte-addressable data RAM for the MEM stage with sized
// loads/stores, fault detection and a valid/ready response channel (RD_LAT 1 or 2).
module data_ram_lsu #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_ce,
  input  logic              i_req,
  output logic              o_ready,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [31:0]       i_w_data,
  output logic              o_rvalid,
  input  logic              i_rready,
  output logic [31:0]       o_r_data,
  output logic [ADDR_W-1:0] o_r_addr,
  output logic              o_err
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_word;
  logic              advance;
  logic              accept;
  logic              misaligned;
  logic              out_of_range;
  logic              fault;
  logic [ADDR_W-3:0] word_addr;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        lane_en;
  logic [31:0]       lane_data;

  logic              s1_valid;
  logic              s1_we;
  logic              s1_err;
  logic [1:0]        s1_off;
  logic [1:0]        s1_size;
  logic              s1_uns;
  logic [ADDR_W-1:0] s1_addr;
  logic [31:0]       s1_data;
  logic              s1_pop;

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                          input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
      SZ_HALF: r = {{16{h[15] & ~uns}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign o_ready   = !(o_rvalid && !i_rready);
  assign advance   = i_ce && o_ready;
  // Gating with reset keeps a request presented during reset from touching memory.
  assign accept    = advance && i_req && i_Rst_n;
  assign word_addr = i_addr[ADDR_W-1:2];
  assign idx       = i_addr[IDX_W+1:2];

  assign out_of_range = (64'(word_addr) >= 64'(DEPTH));
  assign fault        = misaligned || out_of_range;

  always_comb begin
    lane_en    = 4'b0000;
    lane_data  = i_w_data;
    misaligned = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        lane_en   = 4'b0001 << i_addr[1:0];
        lane_data = {4{i_w_data[7:0]}};
      end
      SZ_HALF: begin
        lane_en    = i_addr[1] ? 4'b1100 : 4'b0011;
        lane_data  = {2{i_w_data[15:0]}};
        misaligned = i_addr[0];
      end
      SZ_WORD: begin
        lane_en    = 4'b1111;
        misaligned = (i_addr[1:0] != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (accept && !fault) begin
      if (i_we) begin
        for (int i = 0; i < 4; i++) begin
          if (lane_en[i]) mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
        end
      end else begin
        rd_word <= mem[idx];
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      s1_valid <= 1'b0;
      s1_we    <= 1'b0;
      s1_err   <= 1'b0;
      s1_off   <= 2'b00;
      s1_size  <= 2'b00;
      s1_uns   <= 1'b0;
      s1_addr  <= '0;
    end else if (advance) begin
      s1_valid <= accept;
      if (accept) begin
        s1_we   <= i_we;
        s1_err  <= fault;
        s1_off  <= i_addr[1:0];
        s1_size <= i_size;
        s1_uns  <= i_unsigned;
        s1_addr <= i_addr;
      end
    end else if (s1_pop) begin
      s1_valid <= 1'b0;
    end
  end

  assign s1_data = (s1_valid && !s1_we && !s1_err) ? extract(rd_word, s1_off, s1_size, s1_uns)
                                                   : 32'h0;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              s2_valid;
      logic              s2_err;
      logic [31:0]       s2_data;
      logic [ADDR_W-1:0] s2_addr;

      always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
          s2_valid <= 1'b0;
          s2_err   <= 1'b0;
          s2_data  <= 32'h0;
          s2_addr  <= '0;
        end else if (advance) begin
          s2_valid <= s1_valid;
          s2_err   <= s1_valid && s1_err;
          s2_data  <= s1_data;
          s2_addr  <= s1_addr;
        end else if (s2_valid && i_rready) begin
          s2_valid <= 1'b0;
        end
      end

      // The first stage only moves together with the output stage.
      assign s1_pop   = 1'b0;
      assign o_rvalid = s2_valid;
      assign o_err    = s2_valid && s2_err;
      assign o_r_data = s2_data;
      assign o_r_addr = s2_addr;
    end else begin : g_lat1
      assign s1_pop   = o_rvalid && i_rready;
      assign o_rvalid = s1_valid;
      assign o_err    = s1_valid && s1_err;
      assign o_r_data = s1_data;
      assign o_r_addr = s1_addr;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_data_ram_lsu.sv
`default_nettype none
// tb_data_ram_lsu: directed and randomized checks of data_ram_lsu at RD_LAT=1 and 2
// against a byte-addressed reference memory and an in-order response queue.
module tb_data_ram_lsu;
  localparam int DEPTH = 256;
  localparam int NB    = DEPTH * 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n, ce, req, we, uns, rready, sel;
  logic [31:0] addr, wdata;
  logic [1:0]  size;

  logic        rdy0, rdy1, vld0, vld1, err0, err1;
  logic [31:0] rd0, rd1, ra0, ra1;
  logic        o_rdy, o_vld, o_err;
  logic [31:0] o_rd, o_ra;

  logic [7:0]  mm [2][NB];
  rsp_t        exp_q[$];
  rsp_t        got_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  data_ram_lsu #(.DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(1)) u_lat1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_ce(ce), .i_req(req && !sel), .o_ready(rdy0),
    .i_we(we), .i_addr(addr), .i_size(size), .i_unsigned(uns), .i_w_data(wdata),
    .o_rvalid(vld0), .i_rready(rready), .o_r_data(rd0), .o_r_addr(ra0), .o_err(err0)
  );

  data_ram_lsu #(.DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(2)) u_lat2 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_ce(ce), .i_req(req && sel), .o_ready(rdy1),
    .i_we(we), .i_addr(addr), .i_size(size), .i_unsigned(uns), .i_w_data(wdata),
    .o_rvalid(vld1), .i_rready(rready), .o_r_data(rd1), .o_r_addr(ra1), .o_err(err1)
  );

  assign o_rdy = sel ? rdy1 : rdy0;
  assign o_vld = sel ? vld1 : vld0;
  assign o_err = sel ? err1 : err0;
  assign o_rd  = sel ? rd1  : rd0;
  assign o_ra  = sel ? ra1  : ra0;

  // Reference: little-endian byte memory; the response is decided at acceptance.
  function automatic void model_accept();
    int          n;
    logic        flt;
    logic [31:0] v;
    rsp_t        r;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    flt = (size == 2'd3) || ((addr % n) != 0) || (addr >= 32'(NB));
    r.addr = addr;
    r.data = 32'h0;
    r.err  = flt;
    if (!flt) begin
      if (we) begin
        for (int i = 0; i < n; i++) mm[sel][int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mm[sel][int'(addr) + i];
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        r.data = v;
      end
    end
    exp_q.push_back(r);
  endfunction

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic tick(output logic acc);
    logic hs;
    #1;
    acc = req && o_rdy && ce && rst_n;
    hs  = o_vld && rready && rst_n;
    if (hs) got_q.push_back('{addr: o_ra, data: o_rd, err: o_err});
    if (acc) model_accept();
    @(negedge clk);
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic u, input logic [31:0] d);
    logic acc;
    int   n = 0;
    req = 1'b1; we = w; addr = a; size = s; uns = u; wdata = d;
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 50);
    req = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL issue_timeout addr=%h not accepted within 50 cycles", a);
    end
  endtask

  task automatic drain();
    logic acc;
    int   n = 0;
    req = 1'b0; rready = 1'b1; ce = 1'b1;
    while (got_q.size() < exp_q.size() && n < 100) begin
      tick(acc);
      n++;
    end
    if (got_q.size() < exp_q.size()) begin
      checks++; errors++;
      $display("FAIL drain_timeout got=%0d responses, required %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({vld0, err0, rd0, ra0, rdy0} !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_lat1 got v=%b e=%b d=%h a=%h r=%b, required 0 0 0 0 1",
               vld0, err0, rd0, ra0, rdy0);
    end
    checks++;
    if ({vld1, err1, rd1, ra1, rdy1} !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_lat2 got v=%b e=%b d=%h a=%h r=%b, required 0 0 0 0 1",
               vld1, err1, rd1, ra1, rdy1);
    end
  endtask

  task automatic test_store_load();
    logic acc;
    int   lat;
    issue(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
    drain();
    rready = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h10; size = 2'd2; uns = 1'b0;
    tick(acc);
    req = 1'b0;
    checks++;
    if (!acc) begin errors++; $display("FAIL load_accept got 0, required 1"); end
    lat = 1;
    while (!o_vld && lat < 10) begin tick(acc); lat++; end
    checks++;
    if (lat != (sel ? 2 : 1)) begin
      errors++; $display("FAIL latency sel=%0d got %0d, required %0d", sel, lat, sel ? 2 : 1);
    end
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL store_load_count got %0d, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL store_load rsp%0d got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_sized();
    issue(1'b1, 32'h10, 2'd2, 1'b0, 32'h0);
    issue(1'b1, 32'h11, 2'd0, 1'b0, 32'h1234_5680);
    issue(1'b0, 32'h11, 2'd0, 1'b0, 32'h0);
    issue(1'b0, 32'h11, 2'd0, 1'b1, 32'h0);
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    issue(1'b0, 32'h10, 2'd1, 1'b0, 32'h0);
    issue(1'b1, 32'h12, 2'd1, 1'b0, 32'hABCD_F00F);
    issue(1'b0, 32'h12, 2'd1, 1'b1, 32'h0);
    issue(1'b0, 32'h12, 2'd1, 1'b0, 32'h0);
    issue(1'b0, 32'h13, 2'd0, 1'b0, 32'h0);
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL sized_count got %0d, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL sized rsp%0d got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_faults();
    issue(1'b1, 32'h20, 2'd2, 1'b0, 32'h1122_3344);
    issue(1'b1, 32'h00, 2'd2, 1'b0, 32'hA5A5_A5A5);
    issue(1'b0, 32'h13, 2'd1, 1'b0, 32'h0);
    issue(1'b1, 32'h22, 2'd2, 1'b0, 32'hFFFF_FFFF);
    issue(1'b1, 32'h21, 2'd1, 1'b0, 32'hFFFF_FFFF);
    issue(1'b1, 32'(NB), 2'd2, 1'b0, 32'hFFFF_FFFF);
    issue(1'b0, 32'(NB) + 32'd4, 2'd0, 1'b0, 32'h0);
    issue(1'b1, 32'h00, 2'd3, 1'b0, 32'h0);
    issue(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
    issue(1'b0, 32'h00, 2'd2, 1'b0, 32'h0);
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL faults_count got %0d, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL faults rsp%0d got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_stall();
    logic [31:0] la [4] = '{32'h10, 32'h20, 32'h00, 32'h11};
    logic        acc;
    int          issued = 0, stall = 0, cyc = 0;
    bit          started = 0;
    rsp_t        snap, cur;
    while ((issued < 4 || got_q.size() < exp_q.size()) && cyc < 60) begin
      if (!started && o_vld) begin started = 1; stall = 3; end
      rready = (stall == 0);
      req = (issued < 4); we = 1'b0; size = 2'd2; uns = 1'b0;
      addr = la[issued < 4 ? issued : 3];
      if (stall > 0) begin
        #1;
        cur = '{addr: o_ra, data: o_rd, err: o_err};
        checks++;
        if (o_rdy !== 1'b0) begin errors++; $display("FAIL stall_ready got %b, required 0", o_rdy); end
        if (stall == 3) snap = cur;
        else begin
          checks++;
          if (cur !== snap || o_vld !== 1'b1) begin
            errors++; $display("FAIL stall_hold got %h v=%b, required %h v=1", cur, o_vld, snap);
          end
        end
        stall--;
      end
      tick(acc);
      if (acc) issued++;
      cyc++;
    end
    drain();
    checks++;
    if (got_q.size() != 4 || exp_q.size() != 4) begin
      errors++; $display("FAIL stall_count got %0d, required 4", got_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stall rsp%0d got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    logic acc;
    for (int w = 0; w < 32; w++) issue(1'b1, 32'(w * 4), 2'd2, 1'b0, $urandom);
    for (int c = 0; c < 300; c++) begin
      rready = ($urandom % 4) != 0;
      ce     = ($urandom % 8) != 0;
      req    = ($urandom % 4) != 0;
      we     = $urandom % 2;
      size   = 2'($urandom % 4);
      uns    = $urandom % 2;
      wdata  = $urandom;
      addr   = (($urandom % 16) == 0) ? 32'(NB) + ($urandom % 64) : ($urandom % 128);
      tick(acc);
    end
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random_count got %0d, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random rsp%0d got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_midflight();
    logic acc;
    issue(1'b1, 32'h40, 2'd2, 1'b0, 32'hCAFE_F00D);
    drain();
    exp_q.delete(); got_q.delete();
    rready = 1'b0; req = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0;
    addr = 32'h40; tick(acc);
    addr = 32'h44; tick(acc);
    // A store held on the request port through reset must never commit.
    we = 1'b1; addr = 32'h40; wdata = 32'h0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_vld, o_err, o_rd} !== {1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_async got v=%b e=%b d=%h, required 0 0 0", o_vld, o_err, o_rd);
    end
    exp_q.delete(); got_q.delete();
    @(negedge clk);
    tick(acc); tick(acc);
    req = 1'b0; rready = 1'b1; rst_n = 1'b1;
    repeat (5) tick(acc);
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL reset_dropped got %0d responses, required 0", got_q.size());
    end
    got_q.delete();
    issue(1'b0, 32'h40, 2'd2, 1'b0, 32'h0);
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL reset_count got %0d, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_readback rsp%0d got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; size = 2'd0;
    uns = 1'b0; wdata = 32'h0; rready = 1'b1; sel = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      test_store_load();
      test_sized();
      test_faults();
      test_stall();
      test_random();
      test_reset_midflight();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_ram_lsu.md
Name: data_ram_lsu

Overview:
Parametrised, pipelined data memory for the core's MEM stage, succeeding the flat word-only data RAM. It adds sized accesses (byte/half/word), byte-lane writes, sign/zero extension on loads, and alignment and range fault detection. It uses a request/response handshake with a configurable read latency and output backpressure. Every accepted request returns exactly one in-order response.

Parameters:
DEPTH, 4096, number of 32-bit words; memory indexed by i_addr[ADDR_W-1:2]
ADDR_W, 32, byte-address width
RD_LAT, 1, request-to-response latency in cycles; legal values 1 or 2

Ports:
i_Clk  input  1  clock, rising edge
i_Rst_n  input  1  asynchronous active-low reset
i_ce  input  1  chip enable; when low, no request is accepted and the pipeline holds
i_req  input  1  request valid
o_ready  output  1  request accepted on the cycle where i_req && o_ready && i_ce
i_we  input  1  1 = store, 0 = load
i_addr  input  ADDR_W  byte address
i_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved
i_unsigned  input  1  load zero-extends when 1, sign-extends when 0
i_w_data  input  32  store data, right-aligned
o_rvalid  output  1  response valid
i_rready  input  1  consumer accepts the response
o_r_data  output  32  load result (extended); 0 for stores and faults
o_r_addr  output  ADDR_W  byte address of the request being responded to
o_err  output  1  response is a fault (misaligned, out of range, or reserved size)

Behaviour:
- Reset (i_Rst_n low, asynchronous): o_rvalid=0, o_err=0, o_r_data=0, o_r_addr=0; all pipeline valid bits cleared; in-flight responses dropped. Memory contents are not reset and are preserved.
- o_ready = !(o_rvalid && !i_rready), i.e. low only while a response is stalled.
- Stall freezes the whole pipeline, including the RD_LAT=2 stage.
- Fault check happens at acceptance:
  - half with addr[0]=1 is a fault
  - word with addr[1:0]!=0 is a fault
  - i_size=11 is a fault
  - addr[ADDR_W-1:2] >= DEPTH is a fault
  - A fault causes no memory write. Its response has o_err=1 and o_r_data=0.
- Store lanes:
  - byte writes i_w_data[7:0] to lane addr[1:0]
  - half writes i_w_data[15:0] to lanes {addr[1],0} and {addr[1],1}
  - word writes all four lanes
  - Unselected lanes are unchanged.
  - The write takes effect on the acceptance edge.
- Load:
  - The word is read synchronously on the acceptance edge; addr[1:0], size and unsigned are registered with it.
  - Lane extraction and extension use the registered fields.
  - Byte: bit 7 of the selected lane is extended.
  - Half: bit 15 of the selected halfword is extended.
- Latency:
  - RD_LAT=1: a request accepted at edge N gives o_rvalid from after edge N until the handshake completes.
  - RD_LAT=2: one additional output register stage.
  - Store responses follow the same latency, with o_r_data=0 and o_err=0.
- Ordering: responses come in acceptance order; throughput is 1 request per cycle when i_rready=1.
- Store then load to the same word in back-to-back cycles: the load returns the updated data. No hazard exists because the write commits on the earlier edge.
- Outputs hold stable while o_rvalid && !i_rready.
- i_ce low: no acceptance and the pipeline holds. A pending response stays valid and can still complete via i_rready.
- Reset asserted mid-request: the request is discarded. No partial write is allowed; a write is committed only on a clock edge with i_Rst_n high.

Test Plan:
- Store word 0xDEADBEEF to 0x10, then load word 0x10 (RD_LAT=1) -> o_rvalid one cycle after acceptance, o_r_data=0xDEADBEEF, o_r_addr=0x10, o_err=0.
- Store byte 0x80 to 0x11 over word 0x00000000, then load byte 0x11 signed and unsigned -> 0xFFFFFF80 and 0x00000080; load word 0x10 -> 0x00008000.
- Load half from 0x13 and store word to 0x22 -> each gets o_err=1 and o_r_data=0; a subsequent load of word 0x20 shows it unchanged.
- Address DEPTH*4 with i_size=10, and i_size=11 at address 0 -> o_err=1, no write.
- Stream 4 loads with i_rready held low for 3 cycles after the first response -> o_ready=0 during the stall, outputs stable, all 4 responses in order, none lost or duplicated; repeat with RD_LAT=2 for 2-cycle latency.
- Assert i_Rst_n low with 2 loads in flight -> o_rvalid=0 immediately, no responses after release; previously stored data still readable.
